// File: rtl/alu_seq_pkg.sv
// Shared definitions for the multi-cycle multiply/divide sequencer:
// state encoding, operation codes and bit-counter width.
package alu_seq_pkg;

  localparam int DATA_W = 8;
  localparam int CNT_W  = $clog2(DATA_W);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    LOAD   = 2'b01,
    CALC   = 2'b10,
    FINISH = 2'b11
  } state_t;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

endpackage

// File: rtl/alu_seq_datapath.sv
// Shared ACC/Q/M register set with one adder/subtractor: shift-add multiply
// and restoring divide, one bit per step. Exposes the post-step values.
module alu_seq_datapath
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] acc_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] m_reg;
  logic [WIDTH:0]   opnd;
  logic [WIDTH:0]   addsub;
  logic             carry;

  always_comb begin
    // Divide works on {ACC,Q} already shifted left; multiply on ACC as is.
    opnd     = (op == OP_DIV) ? {acc_reg, q_reg[WIDTH-1]} : {1'b0, acc_reg};
    addsub   = (op == OP_DIV) ? (opnd - {1'b0, m_reg}) : (opnd + {1'b0, m_reg});
    carry    = addsub[WIDTH];
    acc_next = acc_reg;
    q_next   = q_reg;
    if (op == OP_DIV) begin
      // carry is the sign of T here: set means T < 0, so restore.
      if (!carry) begin
        acc_next = addsub[WIDTH-1:0];
        q_next   = {q_reg[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = opnd[WIDTH-1:0];
        q_next   = {q_reg[WIDTH-2:0], 1'b0};
      end
    end else if (q_reg[0]) begin
      {acc_next, q_next} = {carry, addsub[WIDTH-1:0], q_reg[WIDTH-1:1]};
    end else begin
      {acc_next, q_next} = {1'b0, acc_reg, q_reg[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_reg <= '0;
      q_reg   <= '0;
      m_reg   <= '0;
    end else if (load) begin
      acc_reg <= '0;
      q_reg   <= a;
      m_reg   <= b;
    end else if (step) begin
      acc_reg <= acc_next;
      q_reg   <= q_next;
    end
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Sequencer for multi-cycle multiply/divide: FSM, bit counter, operand
// capture and registered result/strobe outputs around alu_seq_datapath.
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_hi,
  output logic [WIDTH-1:0] result_lo,
  output logic             div_zero
);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic             op_reg;
  logic             busy_reg, done_reg, div_zero_reg;
  logic [WIDTH-1:0] result_hi_reg, result_lo_reg;
  logic [WIDTH-1:0] acc_next, q_next;
  logic             zero_div;
  logic             cap_en, load_en, step_en, fin_en;

  assign zero_div = (op_reg == OP_DIV) && (b_reg == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = LOAD;
      LOAD:    state_next = zero_div ? FINISH : CALC;
      CALC:    if (cnt_reg == '0) state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cap_en  = (state_reg == IDLE) && start;
    load_en = (state_reg == LOAD);
    step_en = (state_reg == CALC);
    fin_en  = (state_next == FINISH);
  end

  alu_seq_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk      (clk),
    .rst      (rst),
    .load     (load_en),
    .step     (step_en),
    .op       (op_reg),
    .a        (a_reg),
    .b        (b_reg),
    .acc_next (acc_next),
    .q_next   (q_next)
  );

  // Results load on entry to FINISH so they appear together with DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg       <= '0;
      a_reg         <= '0;
      b_reg         <= '0;
      op_reg        <= OP_MUL;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      div_zero_reg  <= 1'b0;
      result_hi_reg <= '0;
      result_lo_reg <= '0;
    end else begin
      busy_reg <= (state_next != IDLE);
      done_reg <= fin_en;
      if (cap_en) begin
        a_reg        <= a;
        b_reg        <= b;
        op_reg       <= op;
        div_zero_reg <= 1'b0;
      end
      if (load_en)      cnt_reg <= CNT_W'(WIDTH - 1);
      else if (step_en) cnt_reg <= cnt_reg - 1'b1;
      if (fin_en) begin
        if (load_en) begin
          result_hi_reg <= a_reg;
          result_lo_reg <= '1;
          div_zero_reg  <= 1'b1;
        end else begin
          result_hi_reg <= acc_next;
          result_lo_reg <= q_next;
        end
      end
    end
  end

  assign busy      = busy_reg;
  assign done      = done_reg;
  assign result_hi = result_hi_reg;
  assign result_lo = result_lo_reg;
  assign div_zero  = div_zero_reg;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl: multiply, divide, zero divide, busy
// protection and mid-operation reset against hand-computed results.
module tb_alu_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       op = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       busy, done, div_zero;
  logic [7:0] result_hi, result_lo;

  int check_cnt = 0;
  int pass_cnt  = 0;
  logic [7:0] prev_hi = 8'h00;
  logic [7:0] prev_lo = 8'h00;

  always #5 clk = ~clk;

  alu_seq_ctrl #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result_hi (result_hi),
    .result_lo (result_lo),
    .div_zero  (div_zero)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    check_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // One operation: pulse START, follow it cycle by cycle until DONE.
  task automatic run_op(input string tag, input logic o, input logic [7:0] x, input logic [7:0] y,
                        input int exp_lat, input logic [7:0] ehi, input logic [7:0] elo, input logic edz);
    int lat = 0;
    int busy_low = 0;
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      @(negedge clk);
      if (i == 1) begin
        check({tag, "_dz_clr"}, div_zero, 1'b0);
        check({tag, "_hold"}, {result_hi, result_lo}, {prev_hi, prev_lo});
      end
      if (!busy) busy_low++;
      if (done) lat = i;
    end
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_busy"}, busy_low, 0);
    check({tag, "_hi"}, result_hi, ehi);
    check({tag, "_lo"}, result_lo, elo);
    check({tag, "_dz"}, div_zero, edz);
    @(negedge clk);
    check({tag, "_strobe"}, {done, busy}, 2'b00);
    check({tag, "_held"}, {result_hi, result_lo}, {ehi, elo});
    $display("%s: op=%0d a=%02h b=%02h -> hi=%02h lo=%02h dz=%0d lat=%0d",
             tag, o, x, y, result_hi, result_lo, div_zero, lat);
    prev_hi = ehi;
    prev_lo = elo;
  endtask

  initial begin
    int lat, lat2, n_done, seen;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_in", {busy, done, div_zero, result_hi, result_lo}, '0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_out", {busy, done, div_zero, result_hi, result_lo}, '0);
    $display("reset: busy=%0d done=%0d hi=%02h lo=%02h", busy, done, result_hi, result_lo);

    run_op("mul13x11", 1'b0, 8'd13,  8'd11,  10, 8'h00, 8'h8F, 1'b0);
    run_op("mulFFxFF", 1'b0, 8'hFF,  8'hFF,  10, 8'hFE, 8'h01, 1'b0);
    run_op("div200_7", 1'b1, 8'd200, 8'd7,   10, 8'h04, 8'h1C, 1'b0);
    run_op("div5_9",   1'b1, 8'd5,   8'd9,   10, 8'h05, 8'h00, 1'b0);
    run_op("div_zero", 1'b1, 8'h3C,  8'h00,   2, 8'h3C, 8'hFF, 1'b1);
    run_op("mul_after_dz", 1'b0, 8'd13, 8'd11, 10, 8'h00, 8'h8F, 1'b0);

    // Busy protection: START held, operands changed mid-operation
    lat = 0; lat2 = 0; n_done = 0;
    @(negedge clk);
    op = 1'b0; a = 8'd13; b = 8'd11; start = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (i == 3) begin a = 8'hFF; b = 8'hFF; end
      if (done) begin
        n_done++;
        if (lat == 0) begin
          lat = i;
          check("bp_first", {result_hi, result_lo}, 16'h008F);
        end else begin
          lat2 = i;
          check("bp_second", {result_hi, result_lo}, 16'hFE01);
        end
      end
      if (i == 11) check("bp_idle_after_done", busy, 1'b0);
      if (i == 12) begin
        check("bp_restart", busy, 1'b1);
        start = 1'b0;
      end
    end
    check("bp_ndone", n_done, 2);
    check("bp_lat", lat, 10);
    check("bp_lat2", lat2, 21);
    $display("busy_prot: dones=%0d lat=%0d lat2=%0d hi=%02h lo=%02h", n_done, lat, lat2, result_hi, result_lo);

    // Reset in cycle 5 of a divide
    @(negedge clk);
    op = 1'b1; a = 8'd200; b = 8'd7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_out", {busy, done, div_zero, result_hi, result_lo}, '0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    check("mid_rst_quiet", seen, 0);
    $display("mid_reset: busy=%0d hi=%02h lo=%02h activity=%0d", busy, result_hi, result_lo, seen);
    prev_hi = 8'h00;
    prev_lo = 8'h00;

    run_op("div_after_rst", 1'b1, 8'd200, 8'd7, 10, 8'h04, 8'h1C, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
